// File: rtl/circle_if.sv
// Request/pixel bundle between the control FSM, the circle engine and the vga_adapter sink.
// master = requester and pixel sink side, slave = circle engine.
interface circle_if #(
   parameter int X_W     = 8,
   parameter int Y_W     = 7,
   parameter int R_W     = 7,
   parameter int COLOR_W = 3
);
   logic               start;
   logic [X_W-1:0]     centre_x;
   logic [Y_W-1:0]     centre_y;
   logic [R_W-1:0]     radius;
   logic [COLOR_W-1:0] colour;
   logic               fill;
   logic               plot_ready;
   logic               busy;
   logic               done;
   logic [X_W-1:0]     vga_x;
   logic [Y_W-1:0]     vga_y;
   logic [COLOR_W-1:0] vga_colour;
   logic               vga_plot;

   modport master (
      output start, centre_x, centre_y, radius, colour, fill, plot_ready,
      input  busy, done, vga_x, vga_y, vga_colour, vga_plot
   );

   modport slave (
      input  start, centre_x, centre_y, radius, colour, fill, plot_ready,
      output busy, done, vga_x, vga_y, vga_colour, vga_plot
   );
endinterface

// File: rtl/circle_engine.sv
// Midpoint circle rasteriser (outline or filled, clipped): one pixel slot per cycle, 1 INIT + 9 cycles/octant step.
// A visible pixel holds all vga outputs and the FSM until plot_ready; clipped slots never stall.
module circle_engine #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int R_W      = 7,
   parameter int COLOR_W  = 3,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic    clk,
   input  logic    reset,
   circle_if.slave circ
);
   localparam int MW = (X_W > Y_W) ? X_W : Y_W;
   localparam int CW = ((MW > R_W) ? MW : R_W) + 3;

   typedef logic signed [CW-1:0] sw_t;
   typedef enum logic [2:0] {S_IDLE, S_INIT, S_PLOT, S_STEP, S_DONE} state_t;

   localparam sw_t ZERO  = '0;
   localparam sw_t ONE   = sw_t'(1);
   localparam sw_t SCR_W = sw_t'(SCREEN_W);
   localparam sw_t SCR_H = sw_t'(SCREEN_H);

   state_t             state_q, state_d;
   sw_t                cx_q, cx_d, cy_q, cy_d, r_q, r_d;
   sw_t                x_q, x_d, y_q, y_d, d_q, d_d, xo_q, xo_d;
   logic [COLOR_W-1:0] col_q, col_d;
   logic               fill_q, fill_d;
   logic [2:0]         slot_q, slot_d;

   sw_t  px, py, w, x_n, y_n;
   logic in_range, plot, last, d_pos;

   // Pixel for the current slot; in fill mode slot_q[1:0] is the span and xo_q the offset from cx.
   always_comb begin
      px = cx_q;
      py = cy_q;
      w  = slot_q[1] ? y_q : x_q;
      if (fill_q) begin
         px = cx_q + xo_q;
         case (slot_q[1:0])
            2'd0:    py = cy_q + y_q;
            2'd1:    py = cy_q - y_q;
            2'd2:    py = cy_q + x_q;
            default: py = cy_q - x_q;
         endcase
      end else begin
         case (slot_q)
            3'd0:    begin px = cx_q + x_q; py = cy_q + y_q; end
            3'd1:    begin px = cx_q + y_q; py = cy_q + x_q; end
            3'd2:    begin px = cx_q - y_q; py = cy_q + x_q; end
            3'd3:    begin px = cx_q - x_q; py = cy_q + y_q; end
            3'd4:    begin px = cx_q - x_q; py = cy_q - y_q; end
            3'd5:    begin px = cx_q - y_q; py = cy_q - x_q; end
            3'd6:    begin px = cx_q + y_q; py = cy_q - x_q; end
            default: begin px = cx_q + x_q; py = cy_q - y_q; end
         endcase
      end
      in_range = !px[CW-1] && (px < SCR_W) && !py[CW-1] && (py < SCR_H);
      plot     = (state_q == S_PLOT) && in_range;
      last     = (r_q == ZERO) ||
                 (fill_q ? ((slot_q[1:0] == 2'd3) && (xo_q == w)) : (slot_q == 3'd7));
   end

   always_comb begin
      state_d = state_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      r_d     = r_q;
      col_d   = col_q;
      fill_d  = fill_q;
      x_d     = x_q;
      y_d     = y_q;
      d_d     = d_q;
      xo_d    = xo_q;
      slot_d  = slot_q;
      d_pos   = !d_q[CW-1] && (d_q != ZERO);
      y_n     = y_q + ONE;
      x_n     = d_pos ? (x_q - ONE) : x_q;
      case (state_q)
         S_IDLE: begin
            if (circ.start) begin
               cx_d    = sw_t'(circ.centre_x);
               cy_d    = sw_t'(circ.centre_y);
               r_d     = sw_t'(circ.radius);
               col_d   = circ.colour;
               fill_d  = circ.fill;
               state_d = S_INIT;
            end
         end
         S_INIT: begin
            x_d     = r_q;
            y_d     = ZERO;
            d_d     = ONE - r_q;
            xo_d    = -r_q;
            slot_d  = 3'd0;
            state_d = S_PLOT;
         end
         S_PLOT: begin
            if (!plot || circ.plot_ready) begin
               if (last) begin
                  state_d = (r_q == ZERO) ? S_DONE : S_STEP;
               end else if (fill_q && (xo_q != w)) begin
                  xo_d = xo_q + ONE;
               end else begin
                  slot_d = slot_q + 3'd1;
                  // Spans 0->1 reuse half-width x, spans 1->2 and 2->3 use y.
                  xo_d   = (slot_q[1:0] == 2'd0) ? -x_q : -y_q;
               end
            end
         end
         S_STEP: begin
            y_d     = y_n;
            x_d     = x_n;
            d_d     = d_pos ? (d_q + ((y_n - x_n) <<< 1) + ONE) : (d_q + (y_n <<< 1) + ONE);
            xo_d    = -x_n;
            slot_d  = 3'd0;
            state_d = (y_n <= x_n) ? S_PLOT : S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cx_q    <= ZERO;
         cy_q    <= ZERO;
         r_q     <= ZERO;
         col_q   <= '0;
         fill_q  <= 1'b0;
         x_q     <= ZERO;
         y_q     <= ZERO;
         d_q     <= ZERO;
         xo_q    <= ZERO;
         slot_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         r_q     <= r_d;
         col_q   <= col_d;
         fill_q  <= fill_d;
         x_q     <= x_d;
         y_q     <= y_d;
         d_q     <= d_d;
         xo_q    <= xo_d;
         slot_q  <= slot_d;
      end
   end

   assign circ.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
   assign circ.done       = (state_q == S_DONE);
   assign circ.vga_plot   = plot;
   assign circ.vga_x      = plot ? px[X_W-1:0] : '0;
   assign circ.vga_y      = plot ? py[Y_W-1:0] : '0;
   assign circ.vga_colour = col_q;
endmodule

// File: tb/tb_circle_engine.sv
// Directed bench for circle_engine: reference rasteriser feeds a scoreboard queue,
// a negedge monitor pops it on every pixel transfer and checks stall stability.
module tb_circle_engine;
   localparam int X_W = 8, Y_W = 7, R_W = 7, COLOR_W = 3, SW = 160, SH = 120;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   circle_if #(.X_W(X_W), .Y_W(Y_W), .R_W(R_W), .COLOR_W(COLOR_W)) circ();

   circle_engine #(.X_W(X_W), .Y_W(Y_W), .R_W(R_W), .COLOR_W(COLOR_W),
                   .SCREEN_W(SW), .SCREEN_H(SH)) dut (
      .clk   (clk),
      .reset (reset),
      .circ  (circ)
   );

   int checks    = 0;
   int errors    = 0;
   int exp_q[$];
   int log_q[$];
   int done_cnt  = 0;
   int stall_cnt = 0;
   bit rand_ready = 1'b0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int pixel_key(int x, int y, int c);
      return (x << 16) | (y << 4) | c;
   endfunction

   function automatic void push(int x, int y, int c);
      if (x >= 0 && x < SW && y >= 0 && y < SH) exp_q.push_back(pixel_key(x, y, c));
   endfunction

   function automatic void span(int y, int xl, int xr, int c);
      for (int i = xl; i <= xr; i++) push(i, y, c);
   endfunction

   function automatic void model(int cx, int cy, int r, bit f, int c);
      int x = r;
      int y = 0;
      int d = 1 - r;
      if (r == 0) begin
         push(cx, cy, c);
         return;
      end
      while (y <= x) begin
         if (!f) begin
            push(cx + x, cy + y, c); push(cx + y, cy + x, c);
            push(cx - y, cy + x, c); push(cx - x, cy + y, c);
            push(cx - x, cy - y, c); push(cx - y, cy - x, c);
            push(cx + y, cy - x, c); push(cx + x, cy - y, c);
         end else begin
            span(cy + y, cx - x, cx + x, c);
            span(cy - y, cx - x, cx + x, c);
            span(cy + x, cx - y, cx + y, c);
            span(cy - x, cx - y, cx + y, c);
         end
         y++;
         if (d <= 0) d += 2 * y + 1;
         else begin
            x--;
            d += 2 * (y - x) + 1;
         end
      end
   endfunction

   // Sink: 50% random acceptance when enabled, otherwise always ready.
   initial begin
      circ.plot_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         circ.plot_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      logic [31:0] pk;
      logic [31:0] pv;
      bit          pst;
      int          k;
      pst = 1'b0;
      pv  = '0;
      forever begin
         @(negedge clk);
         pk = 32'({circ.vga_x, circ.vga_y, circ.vga_colour, circ.vga_plot});
         if (pst) chk("stall hold", pk, pv);
         if (circ.done) done_cnt++;
         if (circ.vga_plot && circ.plot_ready) begin
            k = pixel_key(int'(circ.vga_x), int'(circ.vga_y), int'(circ.vga_colour));
            log_q.push_back(k);
            if (exp_q.size() == 0) chk("unexpected plot", k, 32'hFFFF_FFFF);
            else chk("plot sequence", k, exp_q.pop_front());
         end
         if (circ.vga_plot && !circ.plot_ready) stall_cnt++;
         pst = circ.vga_plot && !circ.plot_ready;
         pv  = pk;
      end
   end

   task automatic wait_done(output int cyc);
      bit seen = 1'b0;
      cyc = 0;
      while (!seen && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (circ.done) seen = 1'b1;
      end
      chk("done seen", 32'(seen), 1);
      if (seen) chk("busy low during done", 32'(circ.busy), 0);
   endtask

   task automatic draw(int cx, int cy, int r, bit f, int c, output int cyc);
      log_q.delete();
      model(cx, cy, r, f, c);
      circ.centre_x = X_W'(cx);
      circ.centre_y = Y_W'(cy);
      circ.radius   = R_W'(r);
      circ.colour   = COLOR_W'(c);
      circ.fill     = f;
      circ.start    = 1'b1;
      @(posedge clk);
      #1;
      circ.start = 1'b0;
      wait_done(cyc);
      chk("scoreboard drained", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cyc, dbefore, lbefore, cnt, x, y, lo, hi;
      bit ok;
      bit [31:0] rowm [32];
      int px2 [8] = '{81, 79, 80, 80, 81, 79, 81, 79};
      int py2 [8] = '{60, 60, 61, 59, 61, 61, 59, 59};

      // 1: reset held with start asserted, then start accepted on release
      circ.start    = 1'b1;
      circ.centre_x = 8'd80;
      circ.centre_y = 7'd60;
      circ.radius   = 7'd1;
      circ.colour   = 3'd5;
      circ.fill     = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy", 32'(circ.busy), 0);
      chk("reset done", 32'(circ.done), 0);
      chk("reset plot", 32'(circ.vga_plot), 0);
      chk("reset vga_x", 32'(circ.vga_x), 0);
      chk("reset vga_y", 32'(circ.vga_y), 0);
      chk("reset colour", 32'(circ.vga_colour), 0);
      @(posedge clk);
      #1;
      log_q.delete();
      model(80, 60, 1, 1'b0, 5);
      reset = 1'b0;
      @(posedge clk);
      #1;
      circ.start = 1'b0;
      @(negedge clk);
      chk("busy after start", 32'(circ.busy), 1);
      wait_done(cyc);
      chk("t1 done cycle", cyc + 1, 20);
      chk("t1 plot count", log_q.size(), 16);
      chk("t1 drained", exp_q.size(), 0);
      @(posedge clk);
      #1;

      // 2: r=1 pixel set, each exactly twice
      draw(80, 60, 1, 1'b0, 2, cyc);
      chk("t2 plot count", log_q.size(), 16);
      for (int i = 0; i < 8; i++) begin
         cnt = 0;
         foreach (log_q[j]) if (log_q[j] == pixel_key(px2[i], py2[i], 2)) cnt++;
         chk("t2 pixel twice", cnt, 2);
      end

      // 3: corner centre clips to the +x/+y quadrant
      draw(0, 0, 5, 1'b0, 3, cyc);
      chk("t3 done cycle", cyc, 38);
      chk("t3 some plots", 32'(log_q.size() > 0), 1);
      foreach (log_q[j]) begin
         x = log_q[j] >> 16;
         y = (log_q[j] >> 4) & 12'hFFF;
         chk("t3 quadrant", 32'(x <= 5 && y <= 5), 1);
      end

      // 4: filled r=2 at (10,10)
      draw(10, 10, 2, 1'b1, 4, cyc);
      foreach (rowm[i]) rowm[i] = '0;
      foreach (log_q[j]) begin
         x = log_q[j] >> 16;
         y = (log_q[j] >> 4) & 12'hFFF;
         chk("t4 inside radius", 32'((x - 10) * (x - 10) + (y - 10) * (y - 10) <= 8), 1);
         if (x < 32 && y < 32) rowm[y][x] = 1'b1;
      end
      chk("t4 row10 span", rowm[10], 32'h0000_1F00);
      for (int r = 0; r < 32; r++) begin
         if (rowm[r] != 0) begin
            lo = -1;
            hi = -1;
            for (int b = 0; b < 32; b++) if (rowm[r][b]) begin
               if (lo < 0) lo = b;
               hi = b;
            end
            ok = 1'b1;
            for (int b = lo; b <= hi; b++) if (!rowm[r][b]) ok = 1'b0;
            chk("t4 row gapless", 32'(ok), 1);
         end
      end

      // 5: random plot_ready, sequence still matches the unstalled reference
      rand_ready = 1'b1;
      stall_cnt  = 0;
      draw(50, 40, 3, 1'b0, 6, cyc);
      draw(50, 40, 3, 1'b1, 1, cyc);
      rand_ready = 1'b0;
      chk("t5 stalls exercised", 32'(stall_cnt > 0), 1);
      @(posedge clk);
      #1;

      // 6: ignored start while busy, then reset abort
      dbefore = done_cnt;
      log_q.delete();
      model(80, 60, 20, 1'b0, 7);
      circ.centre_x = 8'd80;
      circ.centre_y = 7'd60;
      circ.radius   = 7'd20;
      circ.colour   = 3'd7;
      circ.fill     = 1'b0;
      circ.start    = 1'b1;
      @(posedge clk);
      #1;
      circ.start = 1'b0;
      repeat (30) @(negedge clk);
      chk("t6 busy mid draw", 32'(circ.busy), 1);
      @(posedge clk);
      #1;
      circ.centre_x = 8'd10;
      circ.centre_y = 7'd10;
      circ.radius   = 7'd1;
      circ.colour   = 3'd1;
      circ.start    = 1'b1;
      @(posedge clk);
      #1;
      circ.start = 1'b0;
      @(negedge clk);
      chk("t6 busy after ignored start", 32'(circ.busy), 1);
      repeat (10) @(negedge clk);
      chk("t6 no done before abort", done_cnt, dbefore);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      reset = 1'b0;
      @(negedge clk);
      chk("t6 busy after abort", 32'(circ.busy), 0);
      chk("t6 plot after abort", 32'(circ.vga_plot), 0);
      lbefore = log_q.size();
      repeat (200) @(negedge clk);
      chk("t6 no done after abort", done_cnt, dbefore);
      chk("t6 no plots after abort", log_q.size(), lbefore);
      @(posedge clk);
      #1;

      // 7: radius zero and far-edge clipping
      draw(5, 5, 0, 1'b0, 3, cyc);
      chk("t7 r0 outline cycle", cyc, 3);
      chk("t7 r0 outline plots", log_q.size(), 1);
      draw(159, 119, 0, 1'b1, 2, cyc);
      chk("t7 r0 fill cycle", cyc, 3);
      chk("t7 r0 fill plots", log_q.size(), 1);
      draw(158, 118, 3, 1'b1, 5, cyc);
      foreach (log_q[j]) begin
         x = log_q[j] >> 16;
         y = (log_q[j] >> 4) & 12'hFFF;
         chk("t7 on screen", 32'(x < SW && y < SH), 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
